// File: rtl/decode_stage_if.sv
// Handshake and decoded-bundle signals between fetch, the decode stage and execute.
// The decode stage attaches as slave; the environment drives through master.
interface decode_stage_if #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned RF_ADDR_W    = 5,
    parameter int unsigned ALU_OP_WIDTH = 4
);
    logic                    in_valid_i;
    logic                    in_ready_o;
    logic [31:0]             instr_i;
    logic [XLEN-1:0]         instr_addr_i;
    logic                    compressed_i;
    logic                    flush_i;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic [XLEN-1:0]         pc_o;
    logic [RF_ADDR_W-1:0]    rs1_o;
    logic [RF_ADDR_W-1:0]    rs2_o;
    logic [RF_ADDR_W-1:0]    rd_o;
    logic                    rf_we_o;
    logic [1:0]              rf_write_sel_o;
    logic [ALU_OP_WIDTH-1:0] alu_op_o;
    logic [1:0]              op_a_sel_o;
    logic [1:0]              op_b_sel_o;
    logic [XLEN-1:0]         imm_o;
    logic                    lsu_w_en_o;
    logic                    lsu_r_en_o;
    logic [1:0]              lsu_data_type_o;
    logic                    lsu_sign_extend_o;
    logic [1:0]              csr_op_o;
    logic [11:0]             csr_addr_o;
    logic                    md_en_o;
    logic [2:0]              md_op_o;
    logic                    step_o;
    logic                    last_step_o;
    logic                    jump_o;
    logic                    branch_o;
    logic                    ecall_o;
    logic                    ebreak_o;
    logic                    mret_o;
    logic                    illegal_o;

    modport master (
        output in_valid_i, instr_i, instr_addr_i, compressed_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, pc_o, rs1_o, rs2_o, rd_o, rf_we_o, rf_write_sel_o,
               alu_op_o, op_a_sel_o, op_b_sel_o, imm_o, lsu_w_en_o, lsu_r_en_o,
               lsu_data_type_o, lsu_sign_extend_o, csr_op_o, csr_addr_o, md_en_o, md_op_o,
               step_o, last_step_o, jump_o, branch_o, ecall_o, ebreak_o, mret_o, illegal_o
    );

    modport slave (
        input  in_valid_i, instr_i, instr_addr_i, compressed_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, pc_o, rs1_o, rs2_o, rd_o, rf_we_o, rf_write_sel_o,
               alu_op_o, op_a_sel_o, op_b_sel_o, imm_o, lsu_w_en_o, lsu_r_en_o,
               lsu_data_type_o, lsu_sign_extend_o, csr_op_o, csr_addr_o, md_en_o, md_op_o,
               step_o, last_step_o, jump_o, branch_o, ecall_o, ebreak_o, mret_o, illegal_o
    );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I(+M) decode stage with valid/ready flow control, flush and internal
// two-step sequencing of JAL/JALR/BRANCH. Decode is combinational from the held instruction.
module decode_stage #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned RF_ADDR_W   = 5,
    parameter bit          ENABLE_M    = 1'b1,
    parameter logic [31:0] RESET_INSTR = 32'h0000_0013
) (
    input logic           clk,
    input logic           rst_n,
    decode_stage_if.slave dec_io
);
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcMisc   = 7'b0001111;
    localparam logic [6:0] OpcSystem = 7'b1110011;

    localparam logic [1:0] SelRf   = 2'd0;
    localparam logic [1:0] SelImm  = 2'd1;
    localparam logic [1:0] SelPc   = 2'd2;
    localparam logic [1:0] SelZero = 2'd3;

    localparam logic [1:0] WselAlu = 2'd0;
    localparam logic [1:0] WselLsu = 2'd1;
    localparam logic [1:0] WselMd  = 2'd2;
    localparam logic [1:0] WselCsr = 2'd3;

    localparam logic [3:0] AluAdd  = 4'd0;
    localparam logic [3:0] AluSub  = 4'd1;
    localparam logic [3:0] AluSll  = 4'd2;
    localparam logic [3:0] AluSlt  = 4'd3;
    localparam logic [3:0] AluSltu = 4'd4;
    localparam logic [3:0] AluXor  = 4'd5;
    localparam logic [3:0] AluSrl  = 4'd6;
    localparam logic [3:0] AluSra  = 4'd7;
    localparam logic [3:0] AluOr   = 4'd8;
    localparam logic [3:0] AluAnd  = 4'd9;
    localparam logic [3:0] AluEq   = 4'd10;
    localparam logic [3:0] AluNe   = 4'd11;
    localparam logic [3:0] AluLt   = 4'd12;
    localparam logic [3:0] AluGe   = 4'd13;
    localparam logic [3:0] AluLtu  = 4'd14;
    localparam logic [3:0] AluGeu  = 4'd15;

    logic [31:0]     instr_q;
    logic [XLEN-1:0] pc_q;
    logic            comp_q;
    logic            valid_q;
    logic            step_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    assign opcode = instr_q[6:0];
    assign funct3 = instr_q[14:12];
    assign funct7 = instr_q[31:25];

    logic [XLEN-1:0] i_imm, s_imm, b_imm, u_imm, j_imm, csr_uimm;
    assign i_imm    = XLEN'($signed(instr_q[31:20]));
    assign s_imm    = XLEN'($signed({instr_q[31:25], instr_q[11:7]}));
    assign b_imm    = XLEN'($signed({instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8],
                                     1'b0}));
    assign u_imm    = XLEN'($signed({instr_q[31:12], 12'b0}));
    assign j_imm    = XLEN'($signed({instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21],
                                     1'b0}));
    assign csr_uimm = XLEN'(instr_q[19:15]);

    logic            rf_we, lsu_w, lsu_r, sext, md_en;
    logic            jump, branch, ecall, ebreak, mret, illegal, two_step;
    logic [1:0]      wsel, op_a, op_b, dtype, csr_op;
    logic [3:0]      alu_op;
    logic [2:0]      md_op;
    logic [XLEN-1:0] imm;

    always_comb begin
        rf_we    = 1'b0;
        wsel     = WselAlu;
        alu_op   = AluAdd;
        op_a     = SelRf;
        op_b     = SelRf;
        imm      = '0;
        lsu_w    = 1'b0;
        lsu_r    = 1'b0;
        dtype    = 2'd0;
        sext     = 1'b0;
        csr_op   = 2'd0;
        md_en    = 1'b0;
        md_op    = 3'd0;
        jump     = 1'b0;
        branch   = 1'b0;
        ecall    = 1'b0;
        ebreak   = 1'b0;
        mret     = 1'b0;
        illegal  = 1'b0;
        two_step = 1'b0;

        case (opcode)
            OpcLui: begin
                rf_we = 1'b1;
                op_a  = SelZero;
                op_b  = SelImm;
                imm   = u_imm;
            end
            OpcAuipc: begin
                rf_we = 1'b1;
                op_a  = SelPc;
                op_b  = SelImm;
                imm   = u_imm;
            end
            OpcJal, OpcJalr: begin
                illegal  = (opcode == OpcJalr) && (funct3 != 3'd0);
                jump     = 1'b1;
                two_step = 1'b1;
                op_b     = SelImm;
                // Step 0 writes the link address, step 1 forms the target.
                if (!step_q) begin
                    rf_we = 1'b1;
                    op_a  = SelPc;
                    imm   = comp_q ? XLEN'(2) : XLEN'(4);
                end else begin
                    op_a = (opcode == OpcJalr) ? SelRf : SelPc;
                    imm  = (opcode == OpcJalr) ? i_imm : j_imm;
                end
            end
            OpcBranch: begin
                imm = b_imm;
                case (funct3)
                    3'd0:    alu_op = AluEq;
                    3'd1:    alu_op = AluNe;
                    3'd4:    alu_op = AluLt;
                    3'd5:    alu_op = AluGe;
                    3'd6:    alu_op = AluLtu;
                    3'd7:    alu_op = AluGeu;
                    default: illegal = 1'b1;
                endcase
                branch   = 1'b1;
                two_step = 1'b1;
                if (step_q) begin
                    alu_op = AluAdd;
                    op_a   = SelPc;
                    op_b   = SelImm;
                end
            end
            OpcLoad: begin
                illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
                lsu_r   = 1'b1;
                rf_we   = 1'b1;
                wsel    = WselLsu;
                op_b    = SelImm;
                imm     = i_imm;
                dtype   = funct3[1:0];
                sext    = ~funct3[2];
            end
            OpcStore: begin
                illegal = funct3[2] || (funct3[1:0] == 2'd3);
                lsu_w   = 1'b1;
                op_b    = SelImm;
                imm     = s_imm;
                dtype   = funct3[1:0];
            end
            OpcOpImm: begin
                rf_we = 1'b1;
                op_b  = SelImm;
                imm   = i_imm;
                case (funct3)
                    3'd0: alu_op = AluAdd;
                    3'd1: begin
                        alu_op  = AluSll;
                        illegal = (funct7 != 7'h00);
                    end
                    3'd2: alu_op = AluSlt;
                    3'd3: alu_op = AluSltu;
                    3'd4: alu_op = AluXor;
                    3'd5: begin
                        alu_op  = funct7[5] ? AluSra : AluSrl;
                        illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
                    end
                    3'd6: alu_op = AluOr;
                    default: alu_op = AluAnd;
                endcase
            end
            OpcOp: begin
                rf_we = 1'b1;
                if (funct7 == 7'h01) begin
                    if (ENABLE_M) begin
                        md_en = 1'b1;
                        md_op = funct3;
                        wsel  = WselMd;
                    end else begin
                        illegal = 1'b1;
                    end
                end else if ((funct7 == 7'h00) || (funct7 == 7'h20)) begin
                    case ({funct7[5], funct3})
                        4'b0_000: alu_op = AluAdd;
                        4'b1_000: alu_op = AluSub;
                        4'b0_001: alu_op = AluSll;
                        4'b0_010: alu_op = AluSlt;
                        4'b0_011: alu_op = AluSltu;
                        4'b0_100: alu_op = AluXor;
                        4'b0_101: alu_op = AluSrl;
                        4'b1_101: alu_op = AluSra;
                        4'b0_110: alu_op = AluOr;
                        4'b0_111: alu_op = AluAnd;
                        default:  illegal = 1'b1;
                    endcase
                end else begin
                    illegal = 1'b1;
                end
            end
            OpcMisc: begin
                imm     = i_imm;
                illegal = (funct3 != 3'd0) && (funct3 != 3'd1);
            end
            OpcSystem: begin
                if (funct3 == 3'd0) begin
                    if (instr_q == 32'h0000_0073)      ecall   = 1'b1;
                    else if (instr_q == 32'h0010_0073) ebreak  = 1'b1;
                    else if (instr_q == 32'h3020_0073) mret    = 1'b1;
                    else                               illegal = 1'b1;
                end else if (funct3 == 3'd4) begin
                    illegal = 1'b1;
                end else begin
                    csr_op = funct3[1:0];
                    rf_we  = 1'b1;
                    wsel   = WselCsr;
                    if (funct3[2]) begin
                        op_a = SelImm;
                        imm  = csr_uimm;
                    end
                end
            end
            default: illegal = 1'b1;
        endcase

        // An illegal encoding never drives side effects and always retires in one step.
        if (illegal) begin
            rf_we    = 1'b0;
            wsel     = WselAlu;
            lsu_w    = 1'b0;
            lsu_r    = 1'b0;
            csr_op   = 2'd0;
            md_en    = 1'b0;
            md_op    = 3'd0;
            jump     = 1'b0;
            branch   = 1'b0;
            ecall    = 1'b0;
            ebreak   = 1'b0;
            mret     = 1'b0;
            two_step = 1'b0;
        end
    end

    logic last_step, in_ready, accept;
    assign last_step = ~two_step | step_q;
    assign in_ready  = rst_n & ~dec_io.flush_i & (~valid_q | (dec_io.out_ready_i & last_step));
    assign accept    = dec_io.in_valid_i & in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            step_q  <= 1'b0;
            instr_q <= RESET_INSTR;
            pc_q    <= '0;
            comp_q  <= 1'b0;
        end else if (dec_io.flush_i) begin
            valid_q <= 1'b0;
            step_q  <= 1'b0;
        end else if (accept) begin
            instr_q <= dec_io.instr_i;
            pc_q    <= dec_io.instr_addr_i;
            comp_q  <= dec_io.compressed_i;
            valid_q <= 1'b1;
            step_q  <= 1'b0;
        end else if (valid_q && dec_io.out_ready_i) begin
            if (!last_step) begin
                step_q <= 1'b1;
            end else begin
                valid_q <= 1'b0;
                step_q  <= 1'b0;
            end
        end
    end

    assign dec_io.in_ready_o        = in_ready;
    assign dec_io.out_valid_o       = valid_q;
    assign dec_io.pc_o              = pc_q;
    assign dec_io.rs1_o             = RF_ADDR_W'(instr_q[19:15]);
    assign dec_io.rs2_o             = RF_ADDR_W'(instr_q[24:20]);
    assign dec_io.rd_o              = RF_ADDR_W'(instr_q[11:7]);
    assign dec_io.rf_we_o           = valid_q & rf_we;
    assign dec_io.rf_write_sel_o    = wsel;
    assign dec_io.alu_op_o          = alu_op;
    assign dec_io.op_a_sel_o        = op_a;
    assign dec_io.op_b_sel_o        = op_b;
    assign dec_io.imm_o             = imm;
    assign dec_io.lsu_w_en_o        = valid_q & lsu_w;
    assign dec_io.lsu_r_en_o        = valid_q & lsu_r;
    assign dec_io.lsu_data_type_o   = dtype;
    assign dec_io.lsu_sign_extend_o = sext;
    assign dec_io.csr_op_o          = valid_q ? csr_op : 2'd0;
    assign dec_io.csr_addr_o        = instr_q[31:20];
    assign dec_io.md_en_o           = valid_q & md_en;
    assign dec_io.md_op_o           = md_op;
    assign dec_io.step_o            = step_q;
    assign dec_io.last_step_o       = last_step;
    assign dec_io.jump_o            = valid_q & jump;
    assign dec_io.branch_o          = valid_q & branch;
    assign dec_io.ecall_o           = valid_q & ecall;
    assign dec_io.ebreak_o          = valid_q & ebreak;
    assign dec_io.mret_o            = valid_q & mret;
    assign dec_io.illegal_o         = valid_q & illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: two instances (M enabled / disabled) share stimulus;
// expected step bundles are queued at issue and checked by a negedge monitor.
module tb_decode_stage;
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rf_we;
        logic [1:0]  wsel;
        logic [3:0]  alu;
        logic [1:0]  opa;
        logic [1:0]  opb;
        logic [31:0] imm;
        logic        lsu_w;
        logic        lsu_r;
        logic [1:0]  csr;
        logic        md_en;
        logic [2:0]  md_op;
        logic        step;
        logic        last;
        logic        jump;
        logic        branch;
        logic        ecall;
        logic        ebreak;
        logic        mret;
        logic        illegal;
        logic        in_ready;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decode_stage_if if0 ();
    decode_stage_if if1 ();

    decode_stage #(.ENABLE_M(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .dec_io(if0));
    decode_stage #(.ENABLE_M(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .dec_io(if1));

    int checks = 0;
    int failures = 0;
    exp_t q0[$];
    exp_t q1[$];

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic c);
        if0.in_valid_i = v;   if1.in_valid_i = v;
        if0.instr_i = ins;    if1.instr_i = ins;
        if0.instr_addr_i = pc; if1.instr_addr_i = pc;
        if0.compressed_i = c; if1.compressed_i = c;
    endtask

    task automatic set_ctl(input logic rdy, input logic fl);
        if0.out_ready_i = rdy; if1.out_ready_i = rdy;
        if0.flush_i = fl;      if1.flush_i = fl;
    endtask

    function automatic exp_t mk(input logic [31:0] pc, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [31:0] imm, input logic [1:0] opa,
                                input logic [1:0] opb, input logic [3:0] alu,
                                input logic we, input logic step, input logic last);
        exp_t e;
        e = '0;
        e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.imm = imm;
        e.opa = opa; e.opb = opb; e.alu = alu; e.rf_we = we; e.step = step; e.last = last;
        return e;
    endfunction

    task automatic push2(input exp_t e0, input exp_t e1);
        q0.push_back(e0);
        q1.push_back(e1);
    endtask

    // Present one instruction and hold it until accepted; returns cycles spent stalled.
    task automatic send(input logic [31:0] ins, input logic [31:0] pc, input logic c,
                        output int waited);
        bit acc;
        acc = 1'b0;
        waited = 0;
        drive(1'b1, ins, pc, c);
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = if0.in_ready_o;
            if (!acc) waited++;
            @(posedge clk);
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got no accept required accept of %h", ins);
        end
        #1;
    endtask

    task automatic mon(input int id, input logic v, input exp_t act, input logic rdy,
                       input logic fl);
        exp_t e;
        int n;
        if (v !== 1'b1 || fl !== 1'b0) return;
        n = (id == 0) ? q0.size() : q1.size();
        checks++;
        if (n == 0) begin
            failures++;
            $display("FAIL unexpected_output dut%0d: got %h required none", id, act);
            return;
        end
        e = (id == 0) ? q0[0] : q1[0];
        e.in_ready = rdy & e.last;
        if (act !== e) begin
            failures++;
            $display("FAIL step_bundle dut%0d pc=%h: got %h required %h", id, e.pc, act, e);
        end
        if (rdy) begin
            if (id == 0) void'(q0.pop_front());
            else         void'(q1.pop_front());
        end
    endtask

    always @(negedge clk) begin
        exp_t a0, a1;
        a0 = {if0.pc_o, if0.rs1_o, if0.rs2_o, if0.rd_o, if0.rf_we_o, if0.rf_write_sel_o,
              if0.alu_op_o, if0.op_a_sel_o, if0.op_b_sel_o, if0.imm_o, if0.lsu_w_en_o,
              if0.lsu_r_en_o, if0.csr_op_o, if0.md_en_o, if0.md_op_o, if0.step_o,
              if0.last_step_o, if0.jump_o, if0.branch_o, if0.ecall_o, if0.ebreak_o,
              if0.mret_o, if0.illegal_o, if0.in_ready_o};
        a1 = {if1.pc_o, if1.rs1_o, if1.rs2_o, if1.rd_o, if1.rf_we_o, if1.rf_write_sel_o,
              if1.alu_op_o, if1.op_a_sel_o, if1.op_b_sel_o, if1.imm_o, if1.lsu_w_en_o,
              if1.lsu_r_en_o, if1.csr_op_o, if1.md_en_o, if1.md_op_o, if1.step_o,
              if1.last_step_o, if1.jump_o, if1.branch_o, if1.ecall_o, if1.ebreak_o,
              if1.mret_o, if1.illegal_o, if1.in_ready_o};
        mon(0, if0.out_valid_o, a0, if0.out_ready_i, if0.flush_i);
        mon(1, if1.out_valid_o, a1, if1.out_ready_i, if1.flush_i);
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "timeout");
    end

    localparam logic [1:0] RF = 2'd0, IMM = 2'd1, PC = 2'd2;
    localparam logic [3:0] ADD = 4'd0, EQ = 4'd10;

    initial begin
        exp_t e, e1;
        int w;

        // Reset held for two edges with a valid instruction offered.
        drive(1'b1, 32'h0050_0093, 32'h0, 1'b0);
        set_ctl(1'b1, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check1("rst_out_valid0", {31'b0, if0.out_valid_o}, 32'd0);
        check1("rst_out_valid1", {31'b0, if1.out_valid_o}, 32'd0);
        check1("rst_in_ready", {31'b0, if0.in_ready_o}, 32'd0);
        check1("rst_pc", if0.pc_o, 32'h0);
        check1("rst_step", {31'b0, if0.step_o}, 32'd0);
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        check1("release_in_ready", {31'b0, if0.in_ready_o}, 32'd1);
        check1("release_out_valid", {31'b0, if0.out_valid_o}, 32'd0);

        // Back-to-back single-step instructions.
        e = mk(32'h0, 5'd0, 5'd5, 5'd1, 32'd5, RF, IMM, ADD, 1'b1, 1'b0, 1'b1);
        push2(e, e);
        send(32'h0050_0093, 32'h0, 1'b0, w);
        e = mk(32'h4, 5'd1, 5'd2, 5'd3, 32'd0, RF, RF, ADD, 1'b1, 1'b0, 1'b1);
        push2(e, e);
        send(32'h0020_81B3, 32'h4, 1'b0, w);
        check1("b2b_no_bubble", w, 32'd0);

        // JAL, full-width then compressed.
        e = mk(32'h100, 5'd0, 5'd8, 5'd1, 32'd4, PC, IMM, ADD, 1'b1, 1'b0, 1'b0);
        e.jump = 1'b1;
        push2(e, e);
        e = mk(32'h100, 5'd0, 5'd8, 5'd1, 32'd8, PC, IMM, ADD, 1'b0, 1'b1, 1'b1);
        e.jump = 1'b1;
        push2(e, e);
        send(32'h0080_00EF, 32'h100, 1'b0, w);
        e = mk(32'h200, 5'd0, 5'd8, 5'd1, 32'd2, PC, IMM, ADD, 1'b1, 1'b0, 1'b0);
        e.jump = 1'b1;
        push2(e, e);
        e = mk(32'h200, 5'd0, 5'd8, 5'd1, 32'd8, PC, IMM, ADD, 1'b0, 1'b1, 1'b1);
        e.jump = 1'b1;
        push2(e, e);
        send(32'h0080_00EF, 32'h200, 1'b1, w);
        check1("jal_two_cycles", w, 32'd1);

        // BEQ with three cycles of backpressure on step 0.
        e = mk(32'h300, 5'd1, 5'd2, 5'd8, 32'd8, RF, RF, EQ, 1'b0, 1'b0, 1'b0);
        e.branch = 1'b1;
        push2(e, e);
        e = mk(32'h300, 5'd1, 5'd2, 5'd8, 32'd8, PC, IMM, ADD, 1'b0, 1'b1, 1'b1);
        e.branch = 1'b1;
        push2(e, e);
        send(32'h0020_8463, 32'h300, 1'b0, w);
        check1("jalc_two_cycles", w, 32'd1);
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        set_ctl(1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check1("stall_step", {31'b0, if0.step_o}, 32'd0);
        check1("stall_in_ready", {31'b0, if0.in_ready_o}, 32'd0);
        check1("stall_valid", {31'b0, if0.out_valid_o}, 32'd1);
        set_ctl(1'b1, 1'b0);

        // MUL: decoded by dut0, illegal in dut1.
        e = mk(32'h304, 5'd1, 5'd2, 5'd3, 32'd0, RF, RF, ADD, 1'b1, 1'b0, 1'b1);
        e.wsel = 2'd2;
        e.md_en = 1'b1;
        e1 = mk(32'h304, 5'd1, 5'd2, 5'd3, 32'd0, RF, RF, ADD, 1'b0, 1'b0, 1'b1);
        e1.illegal = 1'b1;
        push2(e, e1);
        send(32'h0220_81B3, 32'h304, 1'b0, w);

        // JALR flushed in step 1 while a new instruction is offered.
        e = mk(32'h400, 5'd1, 5'd16, 5'd1, 32'd4, PC, IMM, ADD, 1'b1, 1'b0, 1'b0);
        e.jump = 1'b1;
        push2(e, e);
        send(32'h0100_80E7, 32'h400, 1'b0, w);
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        set_ctl(1'b1, 1'b1);
        drive(1'b1, 32'h0050_0093, 32'h600, 1'b0);
        @(negedge clk);
        check1("flush_hold_step", {31'b0, if0.step_o}, 32'd1);
        check1("flush_in_ready", {31'b0, if0.in_ready_o}, 32'd0);
        @(posedge clk);
        #1;
        set_ctl(1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        check1("flush_out_valid", {31'b0, if0.out_valid_o}, 32'd0);
        check1("flush_step", {31'b0, if0.step_o}, 32'd0);
        check1("flush_no_accept_pc", if0.pc_o, 32'h400);
        check1("flush_in_ready_after", {31'b0, if0.in_ready_o}, 32'd1);

        // FENCE: legal, no side effects.
        @(posedge clk);
        #1;
        e = mk(32'h500, 5'd0, 5'd31, 5'd0, 32'h0FF, RF, RF, ADD, 1'b0, 1'b0, 1'b1);
        push2(e, e);
        send(32'h0FF0_000F, 32'h500, 1'b0, w);
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check1("queue0_drained", q0.size(), 32'd0);
        check1("queue1_drained", q1.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
